// File: rtl/alu_uart_host.sv
// UART host for the ALU: sends the 7-frame command sequence on tx, then waits
// on rx for the one-byte result and reports it with done/err.
module alu_uart_host #(
   parameter int N            = 8,
   parameter int IDLE_BITS    = 1,
   parameter int TIMEOUT_BITS = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] op,
   input  logic         rx,
   output logic         tx,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [N-1:0] result
);

   localparam int TO_TICKS  = TIMEOUT_BITS * 16;
   localparam int TOW       = $clog2(TO_TICKS + 1);
   localparam int GAP_TICKS = IDLE_BITS * 16;
   localparam int GW        = $clog2(GAP_TICKS + 2);
   localparam int BW        = $clog2(N + 1);

   typedef enum logic [3:0] {
      IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP,
      RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
   } state_t;

   state_t         state;
   logic [3:0]     bit_tick;
   logic [BW-1:0]  bit_idx;
   logic [2:0]     frame;
   logic [GW-1:0]  gap_cnt;
   logic [TOW-1:0] to_cnt;
   logic           first_pending;
   logic [N-1:0]   a_q, b_q, op_q;
   logic [N-1:0]   tx_sh, rx_sh, cur_byte;
   logic           rx_meta, rx_sync;

   always_comb begin
      cur_byte = N'(4);
      case (frame)
         3'd0: cur_byte = N'(1);
         3'd1: cur_byte = a_q;
         3'd2: cur_byte = N'(2);
         3'd3: cur_byte = b_q;
         3'd4: cur_byte = N'(3);
         3'd5: cur_byte = op_q;
         default: cur_byte = N'(4);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         tx            <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         result        <= '0;
         bit_tick      <= '0;
         bit_idx       <= '0;
         frame         <= '0;
         gap_cnt       <= '0;
         to_cnt        <= '0;
         first_pending <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         op_q          <= '0;
         tx_sh         <= '0;
         rx_sh         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a_q           <= a;
               b_q           <= b;
               op_q          <= op;
               busy          <= 1'b1;
               err           <= 1'b0;
               frame         <= '0;
               bit_tick      <= '0;
               first_pending <= 1'b1;
               state         <= TX_START;
            end
            // The first start bit begins on the first tick after acceptance;
            // later start bits begin on the tick that ends the gap.
            TX_START: if (tick) begin
               if (first_pending) begin
                  first_pending <= 1'b0;
                  tx            <= 1'b0;
                  bit_tick      <= '0;
               end else if (bit_tick == 4'd15) begin
                  bit_tick <= '0;
                  tx       <= cur_byte[0];
                  tx_sh    <= cur_byte >> 1;
                  bit_idx  <= '0;
                  state    <= TX_DATA;
               end else begin
                  bit_tick <= bit_tick + 4'd1;
               end
            end
            TX_DATA: if (tick) begin
               if (bit_tick == 4'd15) begin
                  bit_tick <= '0;
                  if (bit_idx == BW'(N - 1)) begin
                     tx    <= 1'b1;
                     state <= TX_STOP;
                  end else begin
                     tx      <= tx_sh[0];
                     tx_sh   <= tx_sh >> 1;
                     bit_idx <= bit_idx + BW'(1);
                  end
               end else begin
                  bit_tick <= bit_tick + 4'd1;
               end
            end
            TX_STOP: if (tick) begin
               if (bit_tick == 4'd15) begin
                  bit_tick <= '0;
                  if (frame == 3'd6) begin
                     to_cnt <= '0;
                     state  <= RX_WAIT;
                  end else if (GAP_TICKS == 0) begin
                     tx    <= 1'b0;
                     frame <= frame + 3'd1;
                     state <= TX_START;
                  end else begin
                     gap_cnt <= '0;
                     state   <= TX_GAP;
                  end
               end else begin
                  bit_tick <= bit_tick + 4'd1;
               end
            end
            TX_GAP: if (tick) begin
               if (gap_cnt == GW'(GAP_TICKS - 1)) begin
                  tx       <= 1'b0;
                  frame    <= frame + 3'd1;
                  bit_tick <= '0;
                  state    <= TX_START;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            // The timeout count survives false starts, so a noisy line cannot
            // keep the host waiting forever.
            RX_WAIT: if (tick) begin
               if (!rx_sync) begin
                  bit_tick <= '0;
                  state    <= RX_START;
               end else if (to_cnt == TOW'(TO_TICKS - 1)) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  to_cnt <= to_cnt + TOW'(1);
               end
            end
            RX_START: if (tick) begin
               if (bit_tick == 4'd7) begin
                  bit_tick <= '0;
                  bit_idx  <= '0;
                  state    <= rx_sync ? RX_WAIT : RX_DATA;
               end else begin
                  bit_tick <= bit_tick + 4'd1;
               end
            end
            RX_DATA: if (tick) begin
               if (bit_tick == 4'd15) begin
                  bit_tick <= '0;
                  rx_sh    <= {rx_sync, rx_sh[N-1:1]};
                  if (bit_idx == BW'(N - 1)) state <= RX_STOP;
                  else bit_idx <= bit_idx + BW'(1);
               end else begin
                  bit_tick <= bit_tick + 4'd1;
               end
            end
            RX_STOP: if (tick) begin
               if (bit_tick == 4'd15) begin
                  bit_tick <= '0;
                  if (rx_sync) begin
                     result <= rx_sh;
                     err    <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  bit_tick <= bit_tick + 4'd1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_host.sv
// Directed bench for alu_uart_host: decodes the transmitted frames from a
// tick-stamped log of tx edges and plays the ALU side of the link on rx.
module tb_alu_uart_host;

   localparam int TX_TICKS = 1216;
   localparam int TO_TICKS = 255 * 16;

   logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0, rx = 1'b1;
   logic [7:0] a = '0, b = '0, op = '0;
   logic       tx, busy, done, err;
   logic [7:0] result;

   int   tests = 0, fails = 0;
   int   tick_count = 0;
   int   chg_ts[$];
   logic chg_val[$];
   logic prev_tx = 1'b1;
   logic last_done = 1'b0;
   int   done_cnt = 0, done_ts = 0;
   logic done_busy = 1'b0, post_busy = 1'b1;
   int   fall_ts = 0, acc_ts = 0, terr = 0;
   logic [7:0] dec [0:6];

   alu_uart_host dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start),
      .a(a), .b(b), .op(op), .rx(rx),
      .tx(tx), .busy(busy), .done(done), .err(err), .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tick <= ~tick;
      if (tick) tick_count <= tick_count + 1;
   end

   // Edge log of tx, stamped with the tick index, plus done bookkeeping.
   always @(negedge clk) begin
      if (tx !== prev_tx) begin
         chg_ts.push_back(tick_count);
         chg_val.push_back(tx);
         prev_tx = tx;
      end
      if (last_done) post_busy = busy;
      last_done = done;
      if (done === 1'b1) begin
         done_cnt++;
         done_ts   = tick_count;
         done_busy = busy;
      end
   end

   task automatic wait_tick_abs(input int target);
      while (tick_count < target) @(negedge clk);
   endtask

   task automatic wait_ticks(input int n);
      wait_tick_abs(tick_count + n);
   endtask

   function automatic logic tx_at(input int t);
      logic v;
      v = 1'b1;
      foreach (chg_ts[i]) if (chg_ts[i] <= t) v = chg_val[i];
      return v;
   endfunction

   task automatic begin_txn(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ov);
      chg_ts.delete();
      chg_val.delete();
      a = av; b = bv; op = ov;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      acc_ts = tick_count;
      tests++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         fails++;
         $display("[TB] FAIL accept: busy=%b err=%b expected busy=1 err=0", busy, err);
      end
      for (int i = 0; i < 20; i++) begin
         if (chg_ts.size() > 0) break;
         @(negedge clk);
      end
      tests++;
      if (chg_ts.size() == 0) begin
         fails++;
         fall_ts = acc_ts + 1;
         $display("[TB] FAIL first_tick: no start bit seen, expected one at tick %0d", acc_ts + 1);
      end else begin
         fall_ts = chg_ts[0];
         if (fall_ts != acc_ts + 1) begin
            fails++;
            $display("[TB] FAIL first_tick: start bit at tick %0d expected %0d", fall_ts, acc_ts + 1);
         end
      end
   endtask

   task automatic decode_tx;
      int t, nxt;
      terr = 0;
      t = fall_ts;
      for (int f = 0; f < 7; f++) begin
         if (tx_at(t + 8) !== 1'b0) terr++;
         for (int i = 0; i < 8; i++) dec[f][i] = tx_at(t + 24 + 16 * i);
         if (tx_at(t + 152) !== 1'b1) terr++;
         foreach (chg_ts[k])
            if (chg_ts[k] > t && chg_ts[k] < t + 160 && ((chg_ts[k] - t) % 16) != 0) terr++;
         if (f < 6) begin
            nxt = -1;
            foreach (chg_ts[k])
               if (nxt < 0 && chg_val[k] === 1'b0 && chg_ts[k] > t + 150) nxt = chg_ts[k];
            if (nxt < 0) begin
               terr++;
               break;
            end
            if (nxt - (t + 160) != 16) terr++;
            t = nxt;
         end else begin
            foreach (chg_ts[k]) if (chg_ts[k] > t + 144) terr++;
         end
      end
   endtask

   task automatic check_frames(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ov);
      logic [7:0] expv [0:6];
      expv = '{8'h01, av, 8'h02, bv, 8'h03, ov, 8'h04};
      decode_tx();
      for (int f = 0; f < 7; f++) begin
         tests++;
         if (dec[f] !== expv[f]) begin
            fails++;
            $display("[TB] FAIL frame%0d: got %h expected %h", f, dec[f], expv[f]);
         end
      end
      tests++;
      if (terr != 0) begin
         fails++;
         $display("[TB] FAIL frame_timing: %0d framing/timing faults expected 0", terr);
      end
   endtask

   task automatic send_frame(input logic [7:0] v, input logic stop_bit);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         wait_ticks(16);
      end
      rx = stop_bit;
      wait_ticks(16);
      rx = 1'b1;
   endtask

   task automatic wait_done(input int target, input int bound, input string name);
      for (int i = 0; i < bound && done_cnt < target; i++) @(negedge clk);
      tests++;
      if (done_cnt < target) begin
         fails++;
         $display("[TB] FAIL %s: done pulses %0d expected %0d", name, done_cnt, target);
      end
   endtask

   task automatic check_end(input string name, input logic exp_err, input logic [7:0] exp_res);
      tests++;
      if (err !== exp_err || result !== exp_res || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL %s: err=%b result=%h busy=%b expected err=%b result=%h busy=0",
                  name, err, result, busy, exp_err, exp_res);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b1;
      a = 8'h05;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if ({tx, busy, done, err, result} !== {4'b1000, 8'h00}) begin
            fails++;
            $display("[TB] FAIL reset: tx/busy/done/err/result=%b%b%b%b/%h expected 1000/00",
                     tx, busy, done, err, result);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      chg_ts.delete();
      chg_val.delete();
      repeat (40) @(negedge clk);
      tests++;
      if (chg_ts.size() != 0 || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_no_frame: tx edges=%0d busy=%b expected 0 edges busy=0",
                  chg_ts.size(), busy);
      end
   endtask

   task automatic test_nominal;
      int base;
      base = done_cnt;
      begin_txn(8'h05, 8'h03, 8'h20);
      wait_tick_abs(fall_ts + TX_TICKS + 10);
      check_frames(8'h05, 8'h03, 8'h20);
      send_frame(8'h08, 1'b1);
      wait_done(base + 1, 400, "nominal_done");
      repeat (30) @(negedge clk);
      check_end("nominal_result", 1'b0, 8'h08);
      tests++;
      if (done_cnt != base + 1 || done_busy !== 1'b1 || post_busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL nominal_done_pulse: pulses=%0d busy_at_done=%b busy_after=%b expected 1/1/0",
                  done_cnt - base, done_busy, post_busy);
      end
   endtask

   task automatic test_ignore_busy;
      int base;
      base = done_cnt;
      begin_txn(8'h05, 8'h03, 8'h20);
      wait_tick_abs(fall_ts + 200);
      a = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_tick_abs(fall_ts + TX_TICKS + 10);
      check_frames(8'h05, 8'h03, 8'h20);
      send_frame(8'h3C, 1'b1);
      wait_done(base + 1, 400, "busy_done");
      repeat (100) @(negedge clk);
      check_end("busy_result", 1'b0, 8'h3C);
      tests++;
      if (done_cnt != base + 1) begin
         fails++;
         $display("[TB] FAIL busy_single_done: pulses=%0d expected 1", done_cnt - base);
      end
   endtask

   task automatic test_timeout;
      int base;
      base = done_cnt;
      begin_txn(8'h11, 8'h22, 8'h33);
      wait_done(base + 1, 12000, "timeout_done");
      @(negedge clk);
      check_end("timeout_result", 1'b1, 8'h3C);
      tests++;
      if (done_ts != fall_ts + TX_TICKS + TO_TICKS) begin
         fails++;
         $display("[TB] FAIL timeout_time: done at tick %0d expected %0d",
                  done_ts, fall_ts + TX_TICKS + TO_TICKS);
      end
   endtask

   task automatic test_glitch;
      int base, nominal;
      base = done_cnt;
      begin_txn(8'h44, 8'h55, 8'h66);
      wait_tick_abs(fall_ts + TX_TICKS + 20);
      rx = 1'b0;
      wait_ticks(4);
      rx = 1'b1;
      wait_done(base + 1, 12000, "glitch_done");
      @(negedge clk);
      check_end("glitch_result", 1'b1, 8'h3C);
      nominal = fall_ts + TX_TICKS + TO_TICKS;
      tests++;
      if (done_ts < nominal || done_ts > nominal + 16) begin
         fails++;
         $display("[TB] FAIL glitch_time: done at tick %0d expected %0d..%0d",
                  done_ts, nominal, nominal + 16);
      end
   endtask

   task automatic test_framing;
      int base;
      base = done_cnt;
      begin_txn(8'h21, 8'h13, 8'h30);
      wait_tick_abs(fall_ts + TX_TICKS + 10);
      send_frame(8'h5A, 1'b0);
      wait_done(base + 1, 400, "framing_done");
      repeat (10) @(negedge clk);
      check_end("framing_result", 1'b1, 8'h3C);
   endtask

   task automatic test_reset_mid;
      int base;
      begin_txn(8'h05, 8'h03, 8'h20);
      wait_tick_abs(fall_ts + 212);
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({tx, busy, done, err, result} !== {4'b1000, 8'h00}) begin
         fails++;
         $display("[TB] FAIL reset_mid: tx/busy/done/err/result=%b%b%b%b/%h expected 1000/00",
                  tx, busy, done, err, result);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      base = done_cnt;
      begin_txn(8'h7E, 8'h81, 8'h10);
      wait_tick_abs(fall_ts + TX_TICKS + 10);
      check_frames(8'h7E, 8'h81, 8'h10);
      send_frame(8'hC3, 1'b1);
      wait_done(base + 1, 400, "fresh_done");
      repeat (10) @(negedge clk);
      check_end("fresh_result", 1'b0, 8'hC3);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_ignore_busy();
      test_timeout();
      test_glitch();
      test_framing();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_uart_host.md
# alu_uart_host

Hardware host for the UART ALU. On a `start` request it serialises the full command sequence over `tx`: opcode-select/value pairs for A, B and the operation, followed by the execute command. It then waits on `rx` for the one-byte result and returns it with `done`/`err` status. It sits on the far end of the UART link from the ALU top and replaces a bench-driven host in system-level loopback. It shares the 16x-oversampling `tick` from `baudrate_generator`.

## Interface
- `N`, 8: data/operand byte width; the frame carries N data bits.
- `IDLE_BITS`, 1: idle (mark) bit-times inserted between consecutive transmitted frames.
- `TIMEOUT_BITS`, 255: bit-times to wait for a result start bit before flagging an error.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle pulse at 16x baud, from `baudrate_generator`.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `a`  in  N  operand A; latched when `start` is accepted.
- `b`  in  N  operand B; latched when `start` is accepted.
- `op`  in  N  operation code byte; latched when `start` is accepted.
- `rx`  in  1  serial input from the ALU top's `tx`; idle high.
- `tx`  out  1  serial output to the ALU top's `rx`; idle high.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle pulse at the end of a transaction, success or error.
- `err`  out  1  status of the last transaction: timeout or framing error; held until the next `start` is accepted.
- `result`  out  N  last correctly received result byte.

## Operation
- Transmit sequence is fixed, 7 frames: 0x01, A, 0x02, B, 0x03, OP, 0x04.
- Frame format:
  - Start bit 0, then N data bits LSB first, then stop bit 1.
  - Each bit lasts exactly 16 ticks.
- Between frames, `tx` is held at 1 for IDLE_BITS×16 ticks. There is no gap after the last frame.
- States:
  - IDLE → TX_START → TX_DATA → TX_STOP → TX_GAP → TX_START … (7 frames).
  - After the 7th stop bit: RX_WAIT → RX_START → RX_DATA → RX_STOP → DONE → IDLE.
- Input synchronisation:
  - `rx` passes through a 2-flop synchroniser.
  - All rx decisions are taken on `tick` cycles using the synchronised value.
- RX_WAIT:
  - Counts ticks.
  - Synchronised rx = 0 on a tick goes to RX_START.
  - Reaching TIMEOUT_BITS×16 ticks sets `err`=1 and goes to DONE.
- RX_START:
  - After 8 ticks, re-sample rx.
  - If rx = 1, the start was a false start: return to RX_WAIT. The timeout counter is not reset.
  - If rx = 0, go to RX_DATA.
- RX_DATA: sample every 16 ticks (mid-bit) and shift LSB first, N samples.
- RX_STOP: after 16 ticks, sample rx.
  - rx = 1: `result` ← shifted byte, `err`=0.
  - rx = 0 (framing error): `err`=1, `result` unchanged.
- DONE: `done`=1 for one cycle, `busy`=0 from the next cycle.
- Other `start` and rx rules:
  - `start` while busy is ignored.
  - Changes to `a`, `b`, `op` after acceptance have no effect.
  - rx activity outside RX_WAIT/RX_* is ignored.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `err`=0, `result`=0, state IDLE, all counters 0.
- Reset mid-transaction: on the cycle after `reset` is sampled high, `tx`=1, the state is IDLE, and all outputs hold their reset values.
- Start acceptance:
  - `start` high in IDLE is accepted on that edge.
  - `busy`=1 and `err`=0 from the next cycle.
- `tx` timing:
  - `tx` falls to 0 on the first `tick` after acceptance.
  - Every subsequent bit edge occurs on the tick that completes 16 ticks of the previous bit.
- Transmit duration: 7×160 + 6×IDLE_BITS×16 ticks from the first start-bit edge to the end of the last stop bit. With defaults this is 1216 ticks.
- `tick` handling:
  - Counters advance only on `tick` cycles.
  - Non-tick cycles hold all bit counters.
- `done`: asserted the cycle after the deciding tick (stop-bit sample or timeout count reached).
- A new `start` may be accepted on the cycle after `done` deasserts, i.e. when `busy`=0.

## Test plan
- Reset: hold `reset` 5 cycles, with `start`=1 during reset → `tx`=1, `busy`=0, `done`=0, `err`=0, `result`=0 throughout, and no frame is started.
- Nominal: `a`=0x05, `b`=0x03, `op`=0x20, `start` pulse.
  - Bench UART decoder captures 01,05,02,03,03,20,04.
  - Each frame is 160 ticks with a valid start and stop bit, and gaps are 16 ticks.
  - Responder returns 0x08 → `result`=0x08, one `done` pulse, `err`=0.
- Ignore while busy: during frame 2, pulse `start` and change `a` to 0xFF → transmitted A stays 0x05, and there is only one `done` for the run.
- Timeout and false start:
  - No response → `done` with `err`=1 exactly TIMEOUT_BITS×16 ticks after entering RX_WAIT; `result` is unchanged.
  - A 4-tick low glitch on `rx` → ignored, and the timeout still fires.
- Framing error: responder sends 0x5A with stop bit 0 → `err`=1, `done` pulses, `result` keeps its prior value.
- Reset mid-operation: assert `reset` during the A data bits → `tx`=1 next cycle, `busy`=0. A fresh `start` then produces the full 7-frame sequence from 0x01.
